// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: host / core handshake bundle for the run sequencer.
//   REQ, ABORT : host run request and abort (levels)
//   DONE       : processor HALT indication (level)
//   START      : hold-at-PC-0 control to the processor
//   BUSY, RUN_DONE, TIMED_OUT, CYCLES, RUN_COUNT : status back to the host
// The slave modport belongs to the sequencer, and the master modport to the
// harness side that drives requests and models the core's DONE.
interface cpu_run_ctrl_if #(
    parameter int unsigned CW = 16
);
    logic          REQ;
    logic          ABORT;
    logic          DONE;
    logic          START;
    logic          BUSY;
    logic          RUN_DONE;
    logic          TIMED_OUT;
    logic [CW-1:0] CYCLES;
    logic [7:0]    RUN_COUNT;

    modport slave (
        input  REQ, ABORT, DONE,
        output START, BUSY, RUN_DONE, TIMED_OUT, CYCLES, RUN_COUNT
    );

    modport master (
        output REQ, ABORT, DONE,
        input  START, BUSY, RUN_DONE, TIMED_OUT, CYCLES, RUN_COUNT
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: host-side run sequencer for the accumulator processor.
// It parks the core with START high. On a host REQ it holds START for
// START_LEN cycles and then releases it. It counts RUN cycles until the core
// raises DONE or the timeout limit is reached, and then reports completion.
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : cpu_run_ctrl_if slave (REQ/ABORT/DONE in, START/BUSY/RUN_DONE/
//           TIMED_OUT/CYCLES/RUN_COUNT out). All outputs are registered.
module cpu_run_ctrl #(
    parameter int unsigned CW          = 16,
    parameter int unsigned START_LEN   = 2,
    parameter int unsigned TIMEOUT_LIM = 32'h0000_FFFF
) (
    input  logic                CLK,
    input  logic                RST_N,
    cpu_run_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [3:0]    LAUNCH_INIT = 4'(START_LEN - 1);
    localparam logic [CW-1:0] TLIM        = CW'(TIMEOUT_LIM);
    localparam bit            TO_EN       = (TIMEOUT_LIM != 0);

    state_t        state_q, state_d;
    logic [3:0]    lcnt_q, lcnt_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic [7:0]    run_count_q, run_count_d;
    logic          timed_out_q, timed_out_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          run_done_q, run_done_d;

    // State and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            lcnt_q      <= '0;
            cycles_q    <= '0;
            run_count_q <= '0;
            timed_out_q <= 1'b0;
            start_q     <= 1'b1;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            cycles_q    <= cycles_d;
            run_count_q <= run_count_d;
            timed_out_q <= timed_out_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            run_done_q  <= run_done_d;
        end
    end

    // Next-state and counter updates. In RUN the priority is ABORT, then DONE,
    // then the timeout.
    always_comb begin
        state_d     = state_q;
        lcnt_d      = lcnt_q;
        cycles_d    = cycles_q;
        run_count_d = run_count_q;
        timed_out_d = timed_out_q;
        unique case (state_q)
            IDLE: begin
                if (bus.REQ && !bus.ABORT) begin
                    state_d     = LAUNCH;
                    lcnt_d      = LAUNCH_INIT;
                    cycles_d    = '0;
                    timed_out_d = 1'b0;
                end
            end
            LAUNCH: begin
                if (bus.ABORT) begin
                    state_d = IDLE;
                end else if (lcnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    lcnt_d = lcnt_q - 4'd1;
                end
            end
            RUN: begin
                if (bus.ABORT) begin
                    state_d = IDLE;
                end else if (bus.DONE) begin
                    state_d     = REPORT;
                    run_count_d = run_count_q + 8'd1;
                end else if (TO_EN && (cycles_q == TLIM)) begin
                    state_d     = REPORT;
                    timed_out_d = 1'b1;
                end else if (cycles_q != '1) begin
                    cycles_d = cycles_q + 1'b1;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The outputs are decoded from the next state, so that the registered copy
    // lines up with the state register.
    always_comb begin
        start_d    = (state_d != RUN);
        busy_d     = (state_d != IDLE);
        run_done_d = (state_d == REPORT);
    end

    assign bus.START     = start_q;
    assign bus.BUSY      = busy_q;
    assign bus.RUN_DONE  = run_done_q;
    assign bus.TIMED_OUT = timed_out_q;
    assign bus.CYCLES    = cycles_q;
    assign bus.RUN_COUNT = run_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl (START_LEN=2, TIMEOUT_LIM=20).
// Inputs are driven and outputs are sampled 1 time unit after each rising edge.
module tb_cpu_run_ctrl;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;

    cpu_run_ctrl_if #(.CW(16)) bus ();

    cpu_run_ctrl #(
        .CW(16),
        .START_LEN(2),
        .TIMEOUT_LIM(20)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"},  32'(bus.START), 32'd1);
        chk({tag, "_busy"},   32'(bus.BUSY), 32'd0);
        chk({tag, "_rdone"},  32'(bus.RUN_DONE), 32'd0);
        chk({tag, "_tout"},   32'(bus.TIMED_OUT), 32'd0);
        chk({tag, "_cycles"}, 32'(bus.CYCLES), 32'd0);
        chk({tag, "_rcount"}, 32'(bus.RUN_COUNT), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        bus.REQ   = 1'b0;
        bus.ABORT = 1'b0;
        bus.DONE  = 1'b0;
        #12;
        chk_reset("rst");
        RST_N = 1'b1;
        steps(2);
        chk_reset("idle");

        // Run 1: one-cycle REQ, DONE after 10 RUN cycles
        bus.REQ = 1'b1;
        step();
        bus.REQ = 1'b0;
        chk("r1_launch_start", 32'(bus.START), 32'd1);
        chk("r1_launch_busy",  32'(bus.BUSY), 32'd1);
        step();
        chk("r1_launch2_start", 32'(bus.START), 32'd1);
        step();
        chk("r1_run_start",  32'(bus.START), 32'd0);
        chk("r1_run_cycles", 32'(bus.CYCLES), 32'd0);
        steps(10);
        chk("r1_cycles10", 32'(bus.CYCLES), 32'd10);
        chk("r1_no_rdone", 32'(bus.RUN_DONE), 32'd0);
        bus.DONE = 1'b1;
        step();
        bus.DONE = 1'b0;
        chk("r1_rep_rdone",  32'(bus.RUN_DONE), 32'd1);
        chk("r1_rep_start",  32'(bus.START), 32'd1);
        chk("r1_rep_busy",   32'(bus.BUSY), 32'd1);
        chk("r1_rep_rcount", 32'(bus.RUN_COUNT), 32'd1);
        chk("r1_rep_cycles", 32'(bus.CYCLES), 32'd10);
        chk("r1_rep_tout",   32'(bus.TIMED_OUT), 32'd0);
        step();
        chk("r1_idle_rdone", 32'(bus.RUN_DONE), 32'd0);
        chk("r1_idle_busy",  32'(bus.BUSY), 32'd0);

        // Run 2: DONE never arrives, timeout at CYCLES == 20
        bus.REQ = 1'b1;
        step();
        bus.REQ = 1'b0;
        steps(2);
        chk("to_run_start", 32'(bus.START), 32'd0);
        steps(20);
        chk("to_cycles20", 32'(bus.CYCLES), 32'd20);
        chk("to_still_run", 32'(bus.START), 32'd0);
        step();
        chk("to_rep_rdone",  32'(bus.RUN_DONE), 32'd1);
        chk("to_rep_tout",   32'(bus.TIMED_OUT), 32'd1);
        chk("to_rep_rcount", 32'(bus.RUN_COUNT), 32'd1);
        chk("to_rep_cycles", 32'(bus.CYCLES), 32'd20);
        step();
        chk("to_idle_start", 32'(bus.START), 32'd1);
        chk("to_idle_busy",  32'(bus.BUSY), 32'd0);
        chk("to_idle_tout",  32'(bus.TIMED_OUT), 32'd1);
        bus.REQ = 1'b1;
        step();
        bus.REQ = 1'b0;
        chk("to_clr_tout",   32'(bus.TIMED_OUT), 32'd0);
        chk("to_clr_cycles", 32'(bus.CYCLES), 32'd0);
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        chk("abl_busy",  32'(bus.BUSY), 32'd0);
        chk("abl_rdone", 32'(bus.RUN_DONE), 32'd0);
        chk("abl_start", 32'(bus.START), 32'd1);

        // Back-to-back runs with REQ held high, DONE after 5 RUN cycles
        bus.REQ = 1'b1;
        for (int r = 1; r <= 3; r++) begin
            step();
            chk("b2b_launch_busy", 32'(bus.BUSY), 32'd1);
            chk("b2b_launch_start", 32'(bus.START), 32'd1);
            steps(2);
            chk("b2b_run_start", 32'(bus.START), 32'd0);
            steps(5);
            chk("b2b_cycles5", 32'(bus.CYCLES), 32'd5);
            bus.DONE = 1'b1;
            step();
            bus.DONE = 1'b0;
            chk("b2b_rdone", 32'(bus.RUN_DONE), 32'd1);
            chk("b2b_rcount", 32'(bus.RUN_COUNT), 32'(1 + r));
            if (r == 3) bus.REQ = 1'b0;
            step();
            chk("b2b_idle_gap", 32'(bus.BUSY), 32'd0);
            chk("b2b_idle_start", 32'(bus.START), 32'd1);
        end

        // ABORT together with DONE on RUN cycle 3
        bus.REQ = 1'b1;
        step();
        bus.REQ = 1'b0;
        steps(2);
        steps(2);
        chk("ab_cycles2_pre", 32'(bus.CYCLES), 32'd2);
        bus.ABORT = 1'b1;
        bus.DONE  = 1'b1;
        step();
        bus.ABORT = 1'b0;
        bus.DONE  = 1'b0;
        chk("ab_busy",   32'(bus.BUSY), 32'd0);
        chk("ab_start",  32'(bus.START), 32'd1);
        chk("ab_rdone",  32'(bus.RUN_DONE), 32'd0);
        chk("ab_cycles", 32'(bus.CYCLES), 32'd2);
        chk("ab_rcount", 32'(bus.RUN_COUNT), 32'd4);
        step();
        chk("ab_rdone2", 32'(bus.RUN_DONE), 32'd0);

        // DONE high during LAUNCH is ignored
        bus.REQ = 1'b1;
        step();
        bus.REQ  = 1'b0;
        bus.DONE = 1'b1;
        step();
        step();
        chk("ld_run_start", 32'(bus.START), 32'd0);
        chk("ld_run_busy",  32'(bus.BUSY), 32'd1);
        chk("ld_no_rdone",  32'(bus.RUN_DONE), 32'd0);
        bus.DONE = 1'b0;
        steps(7);
        bus.DONE = 1'b1;
        step();
        bus.DONE = 1'b0;
        chk("ld_rdone",  32'(bus.RUN_DONE), 32'd1);
        chk("ld_cycles", 32'(bus.CYCLES), 32'd7);
        chk("ld_rcount", 32'(bus.RUN_COUNT), 32'd5);
        step();

        // ABORT in IDLE blocks the request
        bus.REQ   = 1'b1;
        bus.ABORT = 1'b1;
        step();
        chk("ai_busy", 32'(bus.BUSY), 32'd0);
        bus.ABORT = 1'b0;
        step();
        bus.REQ = 1'b0;
        chk("ai_accept_busy", 32'(bus.BUSY), 32'd1);

        // Asynchronous reset in the middle of RUN
        steps(2);
        steps(4);
        chk("ar_cycles4", 32'(bus.CYCLES), 32'd4);
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset("ar");
        #2;
        RST_N = 1'b1;
        step();
        chk_reset("ar_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Host-side run sequencer for the accumulator processor's START/DONE interface. It is the initiator that the processor top answers to. It parks the core by holding START high, releases it on a host request, and counts execution cycles until the core raises DONE (HALT). It then reports completion, or a timeout, back to the host bench/harness. It sits between the test harness (or a future multi-program loader) and the processor top, one instance per core.

Parameters:
CW, 16, width of the execution-cycle counter CYCLES
START_LEN, 2, number of cycles START is held high after a request is accepted (legal range 1..15)
TIMEOUT_LIM, 16'hFFFF, cycle limit in RUN before a timeout is declared; 0 disables the timeout

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ  input  1  host run request, level, sampled only in IDLE
ABORT  input  1  host abort, level, highest priority
DONE  input  1  processor DONE (HALT), level
START  output  1  to processor START; high = core held at PC 0
BUSY  output  1  high whenever state is not IDLE
RUN_DONE  output  1  one-cycle pulse at the end of every completed or timed-out run
TIMED_OUT  output  1  sticky; set by a timeout, cleared when the next REQ is accepted
CYCLES  output  CW  RUN cycles counted before DONE was seen; held until the next accept
RUN_COUNT  output  8  number of successful (non-timeout) runs, wraps 255->0

Behaviour:
- All outputs are registered. On RST_N low (async), state = IDLE, START = 1, BUSY = 0, RUN_DONE = 0, TIMED_OUT = 0, CYCLES = 0, RUN_COUNT = 0. Reset mid-run aborts immediately with the same values.
- States: IDLE, LAUNCH, RUN, REPORT.
- IDLE: START = 1. If REQ = 1 and ABORT = 0 at a clock edge, the request is accepted:
  - state moves to LAUNCH;
  - the launch counter loads START_LEN-1;
  - CYCLES clears to 0 and TIMED_OUT clears to 0.
- LAUNCH: START = 1 for exactly START_LEN cycles, then RUN. DONE is ignored in this state.
- RUN: START = 0 from the first RUN cycle.
  - Each RUN cycle with DONE = 0 increments CYCLES. CYCLES saturates at all-ones.
  - DONE = 1 sampled in RUN moves to REPORT. CYCLES is not incremented on that cycle. RUN_COUNT increments.
  - If TIMEOUT_LIM != 0, CYCLES == TIMEOUT_LIM and DONE = 0, the run times out: move to REPORT, set TIMED_OUT, leave RUN_COUNT unchanged.
- REPORT: lasts exactly 1 cycle. RUN_DONE = 1, START = 1, then IDLE. REQ is ignored during REPORT. A REQ still high in the following IDLE cycle is accepted, so back-to-back runs have a minimum gap of one IDLE cycle.
- ABORT = 1 in LAUNCH or RUN: next state is IDLE and START returns to 1. There is no RUN_DONE pulse. CYCLES holds its value; RUN_COUNT and TIMED_OUT are unchanged.
- ABORT in IDLE blocks acceptance of REQ. ABORT in REPORT has no effect.
- Simultaneous events in RUN, in priority order:
  - ABORT wins over DONE and over timeout.
  - DONE wins over timeout on the same cycle (counted as success).
- BUSY = 1 in LAUNCH, RUN and REPORT.
- Latency: from a REQ-sampling edge, START falls START_LEN cycles later. RUN_DONE rises one cycle after the edge at which DONE is sampled high.

Test Plan:
- Reset then REQ pulsed 1 cycle, DONE raised 10 cycles after START falls (START_LEN=2) -> START high 2 cycles after accept; CYCLES = 10; RUN_DONE single pulse; RUN_COUNT = 1; TIMED_OUT = 0; BUSY drops after REPORT.
- TIMEOUT_LIM=20, DONE never asserted -> REPORT after CYCLES reaches 20; TIMED_OUT = 1; RUN_COUNT unchanged; START back to 1. Next REQ clears TIMED_OUT.
- REQ held high continuously, DONE raised after 5 RUN cycles each run -> runs repeat with one IDLE cycle between REPORT and the next LAUNCH; RUN_COUNT counts 1,2,3; CYCLES = 5 each run.
- ABORT asserted on RUN cycle 3 simultaneously with DONE -> IDLE next cycle; no RUN_DONE; CYCLES = 2; RUN_COUNT unchanged.
- DONE held high during LAUNCH then low, later high at RUN cycle 7 -> LAUNCH DONE ignored; CYCLES = 7.
- RST_N dropped asynchronously mid-RUN (CYCLES = 4) -> all outputs at reset values immediately without a clock edge; START = 1; RUN_COUNT = 0.
